// File: rtl/grid_game_core.sv
// Two-player N x N, K-in-a-row game engine: keyboard cursor, move placement and
// a sequential win scanner that walks only the four lines through the last mark.
module grid_game_core #(
   parameter int N    = 3,
   parameter int K    = 3,
   parameter bit WRAP = 1'b0,
   parameter int CW   = $clog2(N)
) (
   input  logic             Clk,
   input  logic             RESET,
   input  logic [7:0]       keycode,
   input  logic             press,
   output logic [2*N*N-1:0] board_out,
   output logic [CW-1:0]    cursor_row,
   output logic [CW-1:0]    cursor_col,
   output logic             turn,
   output logic             busy,
   output logic [1:0]       winner,
   output logic             error,
   output logic [7:0]       move_count
);
   localparam int SW = CW + 1;
   localparam int IW = $clog2(N*N);
   localparam int NW = CW + 2;
   localparam logic [CW-1:0] LAST      = CW'(N-1);
   localparam logic [CW-1:0] STEP_LAST = CW'(K-2);
   localparam logic [7:0]    CELLS     = 8'(N*N);
   localparam logic [7:0] KEY_W = 8'h1D, KEY_S = 8'h1B, KEY_A = 8'h1C, KEY_D = 8'h23;
   localparam logic [7:0] KEY_SP = 8'h29, KEY_R = 8'h2D;

   typedef enum logic [1:0] {PLAY, SCAN, OVER} state_t;
   state_t state_reg, state_next;

   logic                 press_reg;
   logic [1:0]           cells_reg [N*N];
   logic [CW-1:0]        row_reg, col_reg, row_next, col_next;
   logic                 turn_reg, error_reg;
   logic [1:0]           winner_reg, player_reg;
   logic [7:0]           count_reg;
   logic signed [SW-1:0] org_r_reg, org_c_reg, prb_r_reg, prb_c_reg;
   logic [1:0]           dir_reg;
   logic                 side_reg;
   logic [CW-1:0]        step_reg;
   logic [NW-1:0]        cnt_reg, cnt_next;

   logic key_ev, restart, mv_up, mv_dn, mv_lt, mv_rt, mv_any, place;
   logic [IW-1:0] cur_idx, cand_idx;
   logic cur_empty, in_bounds, hit, side_end, dir_end, win_hit;
   logic signed [SW-1:0] d_r, d_c, cand_r, cand_c;

   assign key_ev  = press & ~press_reg;
   assign restart = key_ev && (keycode == KEY_R);
   assign mv_up   = key_ev && (keycode == KEY_W);
   assign mv_dn   = key_ev && (keycode == KEY_S);
   assign mv_lt   = key_ev && (keycode == KEY_A);
   assign mv_rt   = key_ev && (keycode == KEY_D);
   assign mv_any  = mv_up | mv_dn | mv_lt | mv_rt;
   assign place   = key_ev && (keycode == KEY_SP);

   assign cur_idx   = IW'(row_reg) * IW'(N) + IW'(col_reg);
   assign cur_empty = (cells_reg[cur_idx] == 2'b00);

   always_comb begin
      row_next = row_reg;
      col_next = col_reg;
      if (mv_up) row_next = (row_reg == '0)   ? (WRAP ? LAST : '0)   : row_reg - CW'(1);
      if (mv_dn) row_next = (row_reg == LAST) ? (WRAP ? '0   : LAST) : row_reg + CW'(1);
      if (mv_lt) col_next = (col_reg == '0)   ? (WRAP ? LAST : '0)   : col_reg - CW'(1);
      if (mv_rt) col_next = (col_reg == LAST) ? (WRAP ? '0   : LAST) : col_reg + CW'(1);
   end

   // Probe one cell beyond the current one along the active direction and side.
   always_comb begin
      case (dir_reg)
         2'd0:    begin d_r = '0;     d_c = SW'(1); end
         2'd1:    begin d_r = SW'(1); d_c = '0;     end
         2'd2:    begin d_r = SW'(1); d_c = SW'(1); end
         default: begin d_r = SW'(1); d_c = '1;     end
      endcase
      if (side_reg) begin
         d_r = -d_r;
         d_c = -d_c;
      end
      cand_r    = prb_r_reg + d_r;
      cand_c    = prb_c_reg + d_c;
      in_bounds = !cand_r[SW-1] && (cand_r[CW-1:0] <= LAST) &&
                  !cand_c[SW-1] && (cand_c[CW-1:0] <= LAST);
      cand_idx  = in_bounds ? IW'(cand_r[CW-1:0]) * IW'(N) + IW'(cand_c[CW-1:0]) : '0;
      hit       = in_bounds && (cells_reg[cand_idx] == player_reg);
      side_end  = !hit || (step_reg == STEP_LAST);
      cnt_next  = cnt_reg + NW'(hit);
      dir_end   = side_end && side_reg;
      win_hit   = dir_end && (cnt_next >= NW'(K));
   end

   always_ff @(posedge Clk) begin
      if (!RESET) state_reg <= PLAY;
      else        state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (restart) state_next = PLAY;
      else begin
         case (state_reg)
            PLAY: if (place && cur_empty) state_next = SCAN;
            SCAN: begin
               if (win_hit) state_next = OVER;
               else if (dir_end && dir_reg == 2'd3)
                  state_next = (count_reg == CELLS) ? OVER : PLAY;
            end
            OVER: state_next = OVER;
            default: state_next = PLAY;
         endcase
      end
   end

   always_comb begin
      busy = (state_reg == SCAN);
   end

   always_ff @(posedge Clk) begin
      if (!RESET) begin
         press_reg <= 1'b0;
         for (int i = 0; i < N*N; i++) cells_reg[i] <= 2'b00;
         row_reg <= '0; col_reg <= '0; turn_reg <= 1'b0; error_reg <= 1'b0;
         winner_reg <= 2'b00; count_reg <= 8'd0; player_reg <= 2'b00;
         org_r_reg <= '0; org_c_reg <= '0; prb_r_reg <= '0; prb_c_reg <= '0;
         dir_reg <= 2'd0; side_reg <= 1'b0; step_reg <= '0; cnt_reg <= '0;
      end else begin
         press_reg <= press;
         if (restart) begin
            for (int i = 0; i < N*N; i++) cells_reg[i] <= 2'b00;
            row_reg <= '0; col_reg <= '0; turn_reg <= 1'b0; error_reg <= 1'b0;
            winner_reg <= 2'b00; count_reg <= 8'd0;
         end else begin
            if (mv_any && state_reg != SCAN) begin
               row_reg   <= row_next;
               col_reg   <= col_next;
               error_reg <= 1'b0;
            end
            if (place && state_reg == PLAY) begin
               if (cur_empty) begin
                  cells_reg[cur_idx] <= {turn_reg, ~turn_reg};
                  player_reg <= {turn_reg, ~turn_reg};
                  count_reg  <= count_reg + 8'd1;
                  error_reg  <= 1'b0;
                  org_r_reg  <= $signed({1'b0, row_reg});
                  org_c_reg  <= $signed({1'b0, col_reg});
                  prb_r_reg  <= $signed({1'b0, row_reg});
                  prb_c_reg  <= $signed({1'b0, col_reg});
                  dir_reg <= 2'd0; side_reg <= 1'b0; step_reg <= '0; cnt_reg <= NW'(1);
               end else begin
                  error_reg <= 1'b1;
               end
            end
            if (state_reg == SCAN) begin
               if (!side_end) begin
                  prb_r_reg <= cand_r; prb_c_reg <= cand_c;
                  step_reg  <= step_reg + CW'(1);
                  cnt_reg   <= cnt_next;
               end else if (!side_reg) begin
                  side_reg  <= 1'b1;
                  prb_r_reg <= org_r_reg; prb_c_reg <= org_c_reg;
                  step_reg  <= '0;
                  cnt_reg   <= cnt_next;
               end else if (win_hit) begin
                  winner_reg <= player_reg;
               end else if (dir_reg == 2'd3) begin
                  // No line found: either the board is full or play passes over.
                  if (count_reg == CELLS) winner_reg <= 2'b11;
                  else                    turn_reg   <= ~turn_reg;
               end else begin
                  dir_reg   <= dir_reg + 2'd1;
                  side_reg  <= 1'b0;
                  prb_r_reg <= org_r_reg; prb_c_reg <= org_c_reg;
                  step_reg  <= '0;
                  cnt_reg   <= NW'(1);
               end
            end
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < N*N; gi++) begin : g_board
         assign board_out[2*gi +: 2] = cells_reg[gi];
      end
   endgenerate

   assign cursor_row = row_reg;
   assign cursor_col = col_reg;
   assign turn       = turn_reg;
   assign winner     = winner_reg;
   assign error      = error_reg;
   assign move_count = count_reg;
endmodule

// File: tb/tb_grid_game_core.sv
// Directed bench for grid_game_core: three instances (3x3 clamp, 3x3 wrap, 5x5 K=4)
// checked every idle cycle against a brute-force board model plus literal checks.
module tb_grid_game_core;
   localparam logic [7:0] K_W = 8'h1D, K_S = 8'h1B, K_A = 8'h1C, K_D = 8'h23;
   localparam logic [7:0] K_SP = 8'h29, K_R = 8'h2D;

   logic Clk = 1'b0;
   logic RESET;
   logic [7:0] keycode;
   logic press0, press1, press2;
   always #5 Clk = ~Clk;

   logic [17:0] b0, b1;
   logic [49:0] b2;
   logic [1:0]  cr0, cc0, cr1, cc1;
   logic [2:0]  cr2, cc2;
   logic        t0, t1, t2, bz0, bz1, bz2, e0, e1, e2;
   logic [1:0]  w0, w1, w2;
   logic [7:0]  mc0, mc1, mc2;

   grid_game_core #(.N(3), .K(3), .WRAP(1'b0)) u0 (.Clk(Clk), .RESET(RESET), .keycode(keycode),
      .press(press0), .board_out(b0), .cursor_row(cr0), .cursor_col(cc0), .turn(t0), .busy(bz0),
      .winner(w0), .error(e0), .move_count(mc0));
   grid_game_core #(.N(3), .K(3), .WRAP(1'b1)) u1 (.Clk(Clk), .RESET(RESET), .keycode(keycode),
      .press(press1), .board_out(b1), .cursor_row(cr1), .cursor_col(cc1), .turn(t1), .busy(bz1),
      .winner(w1), .error(e1), .move_count(mc1));
   grid_game_core #(.N(5), .K(4), .WRAP(1'b0)) u2 (.Clk(Clk), .RESET(RESET), .keycode(keycode),
      .press(press2), .board_out(b2), .cursor_row(cr2), .cursor_col(cc2), .turn(t2), .busy(bz2),
      .winner(w2), .error(e2), .move_count(mc2));

   logic [63:0] dboard [3];
   logic [7:0]  drow [3], dcol [3], dmc [3];
   logic [1:0]  dwin [3];
   logic        dturn [3], dbusy [3], derr [3];

   always_comb begin
      dboard[0] = 64'(b0); dboard[1] = 64'(b1); dboard[2] = 64'(b2);
      drow[0] = 8'(cr0); drow[1] = 8'(cr1); drow[2] = 8'(cr2);
      dcol[0] = 8'(cc0); dcol[1] = 8'(cc1); dcol[2] = 8'(cc2);
      dmc[0] = mc0; dmc[1] = mc1; dmc[2] = mc2;
      dwin[0] = w0; dwin[1] = w1; dwin[2] = w2;
      dturn[0] = t0; dturn[1] = t1; dturn[2] = t2;
      dbusy[0] = bz0; dbusy[1] = bz1; dbusy[2] = bz2;
      derr[0] = e0; derr[1] = e1; derr[2] = e2;
   end

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   int m_board [3][25];
   int m_r [3], m_c [3], m_turn [3], m_win [3], m_err [3], m_mc [3];

   function automatic int pn(int i); return (i == 2) ? 5 : 3; endfunction
   function automatic int pk(int i); return (i == 2) ? 4 : 3; endfunction
   function automatic bit pw(int i); return (i == 1); endfunction

   task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic void m_clear(int i);
      for (int j = 0; j < 25; j++) m_board[i][j] = 0;
      m_r[i] = 0; m_c[i] = 0; m_turn[i] = 0; m_win[i] = 0; m_err[i] = 0; m_mc[i] = 0;
   endfunction

   // Brute force: any K-long run of player p anywhere on the board.
   function automatic bit m_has_line(int i, int p);
      int n, k, rr, cc;
      int drs [4];
      int dcs [4];
      bit ok;
      n = pn(i); k = pk(i);
      drs = '{0, 1, 1, 1};
      dcs = '{1, 0, 1, -1};
      for (int r = 0; r < n; r++)
         for (int c = 0; c < n; c++)
            for (int d = 0; d < 4; d++) begin
               ok = 1'b1;
               for (int t = 0; t < k; t++) begin
                  rr = r + t * drs[d];
                  cc = c + t * dcs[d];
                  if (rr < 0 || rr >= n || cc < 0 || cc >= n) ok = 1'b0;
                  else if (m_board[i][rr*n+cc] != p) ok = 1'b0;
               end
               if (ok) return 1'b1;
            end
      return 1'b0;
   endfunction

   function automatic void m_key(int i, logic [7:0] code, bit in_scan);
      int n, idx;
      bit w;
      n = pn(i); w = pw(i);
      if (code == K_R) begin
         m_clear(i);
         return;
      end
      if (in_scan) return;
      case (code)
         K_W: begin m_r[i] = w ? (m_r[i] + n - 1) % n : ((m_r[i] > 0) ? m_r[i] - 1 : 0); m_err[i] = 0; end
         K_S: begin m_r[i] = w ? (m_r[i] + 1) % n : ((m_r[i] < n - 1) ? m_r[i] + 1 : n - 1); m_err[i] = 0; end
         K_A: begin m_c[i] = w ? (m_c[i] + n - 1) % n : ((m_c[i] > 0) ? m_c[i] - 1 : 0); m_err[i] = 0; end
         K_D: begin m_c[i] = w ? (m_c[i] + 1) % n : ((m_c[i] < n - 1) ? m_c[i] + 1 : n - 1); m_err[i] = 0; end
         K_SP: begin
            if (m_win[i] == 0) begin
               idx = m_r[i] * n + m_c[i];
               if (m_board[i][idx] != 0) m_err[i] = 1;
               else begin
                  m_board[i][idx] = m_turn[i] + 1;
                  m_mc[i]++;
                  m_err[i] = 0;
                  if (m_has_line(i, m_turn[i] + 1)) m_win[i] = m_turn[i] + 1;
                  else if (m_mc[i] == n * n)        m_win[i] = 3;
                  else                              m_turn[i] = 1 - m_turn[i];
               end
            end
         end
         default: ;
      endcase
   endfunction

   function automatic logic [63:0] m_vec(int i);
      logic [63:0] v;
      v = '0;
      for (int j = 0; j < pn(i) * pn(i); j++) v = v | (64'(m_board[i][j]) << (2 * j));
      return v;
   endfunction

   always @(negedge Clk) begin
      if (cmp_en) begin
         for (int i = 0; i < 3; i++) begin
            if (!dbusy[i]) begin
               chk($sformatf("u%0d_board", i), dboard[i], m_vec(i));
               chk($sformatf("u%0d_row", i), 64'(drow[i]), 64'(m_r[i]));
               chk($sformatf("u%0d_col", i), 64'(dcol[i]), 64'(m_c[i]));
               chk($sformatf("u%0d_turn", i), 64'(dturn[i]), 64'(m_turn[i]));
               chk($sformatf("u%0d_winner", i), 64'(dwin[i]), 64'(m_win[i]));
               chk($sformatf("u%0d_error", i), 64'(derr[i]), 64'(m_err[i]));
               chk($sformatf("u%0d_moves", i), 64'(dmc[i]), 64'(m_mc[i]));
            end
         end
      end
   end

   task automatic set_press(int i, logic v);
      case (i)
         0: press0 = v;
         1: press1 = v;
         default: press2 = v;
      endcase
   endtask

   task automatic key(int i, logic [7:0] code, int hold, bit in_scan);
      @(posedge Clk);
      #1;
      keycode = code;
      set_press(i, 1'b1);
      @(posedge Clk);
      m_key(i, code, in_scan);
      $display("key u%0d code=%02h hold=%0d", i, code, hold);
      repeat (hold - 1) @(posedge Clk);
      #1 set_press(i, 1'b0);
   endtask

   task automatic place(int i);
      int n, b;
      bit acc;
      n = pn(i);
      b = 0;
      acc = (m_win[i] == 0) && (m_board[i][m_r[i]*n+m_c[i]] == 0);
      key(i, K_SP, 1, 1'b0);
      if (acc) begin
         @(negedge Clk);
         chk($sformatf("u%0d_busy_rise", i), 64'(dbusy[i]), 64'd1);
         while (dbusy[i] && b < 8 * (pk(i) - 1) + 3) begin
            @(negedge Clk);
            b++;
         end
         chk($sformatf("u%0d_busy_bound", i), 64'(dbusy[i]), 64'd0);
      end
   endtask

   task automatic goto(int i, int r, int c);
      int g;
      g = 0;
      while ((m_r[i] != r || m_c[i] != c) && g < 40) begin
         if (m_r[i] < r)      key(i, K_S, 1, 1'b0);
         else if (m_r[i] > r) key(i, K_W, 1, 1'b0);
         else if (m_c[i] < c) key(i, K_D, 1, 1'b0);
         else                 key(i, K_A, 1, 1'b0);
         g++;
      end
   endtask

   task automatic mv(int i, int r, int c);
      goto(i, r, c);
      place(i);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog timeout checks=%0d", checks);
      $fatal(1, "watchdog");
   end

   initial begin
      RESET = 1'b0; keycode = 8'h00; press0 = 1'b0; press1 = 1'b0; press2 = 1'b0;
      for (int i = 0; i < 3; i++) m_clear(i);
      repeat (2) @(posedge Clk);
      #1 RESET = 1'b1;
      @(negedge Clk);
      chk("reset_board", 64'(b0), 64'h0);
      chk("reset_row", 64'(cr0), 64'h0);
      chk("reset_col", 64'(cc0), 64'h0);
      chk("reset_turn", 64'(t0), 64'h0);
      chk("reset_winner", 64'(w0), 64'h0);
      chk("reset_busy", 64'(bz0), 64'h0);
      chk("reset_error", 64'(e0), 64'h0);
      chk("reset_moves", 64'(mc0), 64'h0);
      cmp_en = 1'b1;

      // Cursor edges: clamp on u0, wrap on u1; one D held for several cycles.
      key(0, K_A, 1, 1'b0);
      @(negedge Clk);
      chk("clamp_left_col", 64'(cc0), 64'h0);
      for (int j = 0; j < 5; j++) key(0, K_D, (j == 1) ? 4 : 1, 1'b0);
      @(negedge Clk);
      chk("clamp_right_col", 64'(cc0), 64'h2);
      key(0, K_W, 1, 1'b0);
      key(0, 8'h15, 1, 1'b0);
      key(1, K_A, 1, 1'b0);
      @(negedge Clk);
      chk("wrap_left_col", 64'(cc1), 64'h2);
      chk("wrap_left_row", 64'(cr1), 64'h0);
      key(1, K_W, 1, 1'b0);
      @(negedge Clk);
      chk("wrap_up_row", 64'(cr1), 64'h2);

      // Row win for X on u0, with an occupied-cell attempt by O.
      mv(0, 0, 0);
      place(0);
      @(negedge Clk);
      chk("occupied_error", 64'(e0), 64'h1);
      chk("occupied_moves", 64'(mc0), 64'h1);
      chk("occupied_turn", 64'(t0), 64'h1);
      key(0, K_D, 1, 1'b0);
      @(negedge Clk);
      chk("error_cleared", 64'(e0), 64'h0);
      mv(0, 1, 0); mv(0, 0, 1); mv(0, 1, 1); mv(0, 0, 2);
      chk("row_win_board", 64'(b0), 64'h00295);
      chk("row_win_winner", 64'(w0), 64'h1);
      chk("row_win_turn", 64'(t0), 64'h0);
      place(0);
      @(negedge Clk);
      chk("over_frozen", 64'(b0), 64'h00295);
      key(0, K_R, 1, 1'b0);
      @(negedge Clk);
      chk("restart_board", 64'(b0), 64'h0);

      // Draw on u0: X O X / X O O / O X X.
      mv(0, 0, 0); mv(0, 0, 1); mv(0, 0, 2); mv(0, 1, 1); mv(0, 1, 0);
      mv(0, 1, 2); mv(0, 2, 1); mv(0, 2, 0); mv(0, 2, 2);
      chk("draw_winner", 64'(w0), 64'h3);
      chk("draw_moves", 64'(mc0), 64'h9);
      chk("draw_board", 64'(b0), 64'h16A59);
      key(0, K_R, 1, 1'b0);

      // 5x5, K=4: X on the anti-diagonal.
      mv(2, 0, 3); mv(2, 4, 4); mv(2, 1, 2); mv(2, 4, 3);
      mv(2, 2, 1); mv(2, 4, 2); mv(2, 3, 0);
      chk("anti_diag_winner", 64'(w2), 64'h1);
      chk("anti_diag_moves", 64'(mc2), 64'h7);
      key(2, K_R, 1, 1'b0);

      // Restart aborting a scan; a move key during the scan is dropped.
      key(2, K_SP, 1, 1'b0);
      @(negedge Clk);
      chk("abort_busy_rise", 64'(bz2), 64'h1);
      key(2, K_D, 1, 1'b1);
      @(negedge Clk);
      chk("scan_drop_col", 64'(cc2), 64'h0);
      key(2, K_R, 1, 1'b1);
      @(negedge Clk);
      chk("abort_board", 64'(b2), 64'h0);
      chk("abort_busy", 64'(bz2), 64'h0);
      chk("abort_moves", 64'(mc2), 64'h0);

      repeat (3) @(negedge Clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
